// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the ram_bist sequencer: FSM states, default sizes
// and the test pattern function.
package ram_bist_pkg;

  localparam int DEF_DW     = 8;
  localparam int DEF_AW     = 4;
  localparam int DEF_RD_LAT = 1;

  // The inverted-pass states are declared in every build so the encoding is stable.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_WRITE_INV,
    S_READ_INV,
    S_DRAIN_INV,
    S_DONE
  } state_t;

  // Pattern word for address a; callers truncate to the RAM word width.
  function automatic logic [31:0] exp(input logic [31:0] seed, input logic [31:0] a,
                                      input logic inv);
    logic [31:0] v;
    v = seed + a;
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/ram_bist_dly.sv
// RD_LAT-deep delay line carrying {valid, addr, expected} so each compare lines up
// with the word the RAM returns for that address.
module ram_bist_dly
  import ram_bist_pkg::*;
#(
  parameter int DATA_W = DEF_AW + DEF_DW,
  parameter int STAGES = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data
);

  logic [STAGES-1:0] r_vld_p;
  logic [DATA_W-1:0] r_data_p [STAGES];

  // stage 0 .. STAGES-1: valid is reset, payload only follows it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= i_vld;
      for (int i = 1; i < STAGES; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_data_p[0] <= i_data;
    for (int i = 1; i < STAGES; i++) r_data_p[i] <= r_data_p[i-1];
  end

  assign o_vld  = r_vld_p[STAGES-1];
  assign o_data = r_data_p[STAGES-1];

endmodule

// File: rtl/ram_bist.sv
// March-style BIST sequencer for a single-port synchronous RAM: write seed+a, read
// back, report first mismatch. Define RAM_BIST_INV_PASS_EN to add an inverted pass.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_wr_en,
  input  logic [DW-1:0] ram_out
);

  localparam int            CW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_seed;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_fail, w_fail_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_pass, w_pass_nxt;
  logic [AW-1:0] r_fail_addr;
  logic [DW-1:0] r_fail_data;
  logic [AW-1:0] r_ram_addr, w_addr_nxt, w_addr_inc;
  logic [DW-1:0] r_ram_din, w_din_nxt;
  logic          r_ram_wr_en, w_wr_nxt;
  logic          w_start_acc;
  logic          w_inv;

  logic                w_dly_vld, w_chk_vld, w_mis, w_first;
  logic [AW+DW-1:0]    w_dly_data, w_chk_data;
  logic [AW-1:0]       w_chk_addr;
  logic [DW-1:0]       w_chk_exp;

`ifdef RAM_BIST_INV_PASS_EN
  assign w_inv = (r_state == S_WRITE_INV) || (r_state == S_READ_INV) ||
                 (r_state == S_DRAIN_INV);
  assign w_dly_vld = (r_state == S_READ) || (r_state == S_READ_INV);
`else
  assign w_inv     = 1'b0;
  assign w_dly_vld = (r_state == S_READ);
`endif

  assign w_addr_inc = r_ram_addr + AW'(1);
  // The registered read address is what the RAM sees this cycle, so it feeds the delay line.
  assign w_dly_data = {r_ram_addr, DW'(exp(32'(r_seed), 32'(r_ram_addr), w_inv))};

  ram_bist_dly #(
    .DATA_W(AW + DW),
    .STAGES(RD_LAT)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_dly_vld),
    .i_data(w_dly_data),
    .o_vld (w_chk_vld),
    .o_data(w_chk_data)
  );

  assign w_chk_addr = w_chk_data[AW+DW-1:DW];
  assign w_chk_exp  = w_chk_data[DW-1:0];
  assign w_mis      = w_chk_vld && (ram_out != w_chk_exp);
  assign w_first    = w_mis && !r_fail;
  assign w_fail_nxt = r_fail | w_mis;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_ram_addr;
    w_din_nxt   = r_ram_din;
    w_wr_nxt    = r_ram_wr_en;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_start_acc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_WRITE;
          w_addr_nxt  = '0;
          w_wr_nxt    = 1'b1;
          w_din_nxt   = DW'(exp(32'(seed), 32'd0, 1'b0));
          w_busy_nxt  = 1'b1;
        end
      end
      S_WRITE `ifdef RAM_BIST_INV_PASS_EN , S_WRITE_INV `endif : begin
        if (r_ram_addr == LAST) begin
          w_state_nxt = w_inv ? S_READ_INV : S_READ;
          w_addr_nxt  = '0;
          w_wr_nxt    = 1'b0;
          w_din_nxt   = '0;
        end else begin
          w_addr_nxt = w_addr_inc;
          w_din_nxt  = DW'(exp(32'(r_seed), 32'(w_addr_inc), w_inv));
        end
      end
      S_READ `ifdef RAM_BIST_INV_PASS_EN , S_READ_INV `endif : begin
        if (r_ram_addr == LAST) begin
          w_state_nxt = w_inv ? S_DRAIN_INV : S_DRAIN;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_addr_nxt = w_addr_inc;
        end
      end
      S_DRAIN `ifdef RAM_BIST_INV_PASS_EN , S_DRAIN_INV `endif : begin
        if (r_cnt == CW'(RD_LAT - 1)) begin
`ifdef RAM_BIST_INV_PASS_EN
          if (!w_inv) begin
            w_state_nxt = S_WRITE_INV;
            w_addr_nxt  = '0;
            w_wr_nxt    = 1'b1;
            w_din_nxt   = DW'(exp(32'(r_seed), 32'd0, 1'b1));
          end else
`endif
          begin
            // The last compare lands on this edge, so pass must see it.
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = !w_fail_nxt;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_seed      <= '0;
      r_cnt       <= '0;
      r_fail      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_ram_wr_en <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_ram_addr  <= w_addr_nxt;
      r_ram_din   <= w_din_nxt;
      r_ram_wr_en <= w_wr_nxt;
      if (w_start_acc) begin
        r_seed      <= seed;
        r_fail      <= 1'b0;
        r_pass      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
      end else begin
        r_fail <= w_fail_nxt;
        r_pass <= w_pass_nxt;
        if (w_first) begin
          r_fail_addr <= w_chk_addr;
          r_fail_data <= ram_out;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign ram_wr_en = r_ram_wr_en;

endmodule

// File: tb/tb_ram_bist.sv
// Scoreboard bench for ram_bist: a faulty-RAM model, a pattern-level reference model,
// and a monitor that scores every done pulse against queued expectations.
module tb_ram_bist;

  localparam int N  = 16;
  localparam int RL = 1;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int LAT = 4 * N + 2 * RL + 1;
  localparam bit INV = 1'b1;
`else
  localparam int LAT = 2 * N + RL + 1;
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       busy, done, pass, ram_wr_en;
  logic [3:0] fail_addr, ram_addr;
  logic [7:0] fail_data, ram_din;
  logic [7:0] ram_out;

  logic [7:0] mem [N];
  logic [7:0] sa0 [N];
  logic [7:0] sa1 [N];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic       pass;
    logic [3:0] fa;
    logic [7:0] fd;
    int         lat;
    int         s_cyc;
  } exp_t;

  exp_t q[$];

  ram_bist dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_wr_en(ram_wr_en),
    .ram_out  (ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 16x8 RAM, one-cycle read latency, stuck-at faults applied on the read path.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_din;
    ram_out <= (mem[ram_addr] & ~sa0[ram_addr]) | sa1[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic [3:0] fa, input logic [7:0] fd);
    exp_t e;
    e.pass  = p;
    e.fa    = fa;
    e.fd    = fd;
    e.lat   = LAT;
    e.s_cyc = 0;
    return e;
  endfunction

  // What the RAM returns at each address vs. what was written; first difference wins.
  function automatic exp_t model(input logic [7:0] s);
    exp_t e;
    e = mk(1'b1, 4'h0, 8'h00);
    for (int p = 0; p < (INV ? 2 : 1); p++) begin
      for (int a = 0; a < N; a++) begin
        logic [7:0] w;
        logic [7:0] r;
        w = s + 8'(a);
        if (p == 1) w = ~w;
        r = (w & ~sa0[a]) | sa1[a];
        if (r != w && e.pass) begin
          e.pass = 1'b0;
          e.fa   = 4'(a);
          e.fd   = r;
        end
      end
    end
    return e;
  endfunction

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin
      sa0[a] = 8'h00;
      sa1[a] = 8'h00;
    end
  endtask

  task automatic do_start(input logic [7:0] s, output int s_cyc);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed  = 8'($urandom);
    s_cyc = cyc;
  endtask

  task automatic run(input exp_t e_in, input logic [7:0] s, input int restart_at);
    exp_t e;
    int   sc;
    bit   got;
    e = e_in;
    do_start(s, sc);
    e.s_cyc = sc;
    q.push_back(e);
    chk("busy_after_start", busy, 1);
    chk("first_write_addr", ram_addr, 0);
    chk("first_write_din", ram_din, s);
    got = 1'b0;
    for (int n = 1; n <= 200 && !got; n++) begin
      @(negedge clk);
      if (restart_at != 0 && (cyc - sc + 1) == restart_at) begin
        start = 1'b1;
        seed  = ~s;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: actual no done required done by cycle %0d", LAT);
      void'(q.pop_front());
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: actual done=1 required no pending run");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc - e.s_cyc + 1, e.lat);
        chk("pass", pass, e.pass);
        chk("fail_addr", fail_addr, e.fa);
        chk("fail_data", fail_data, e.fd);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail_addr"}, fail_addr, 0);
    chk({tag, "_fail_data"}, fail_data, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_ram_wr_en"}, ram_wr_en, 0);
  endtask

  initial begin
    int sc;
    clear_faults();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;

    // fault-free, seed 0
    run(mk(1'b1, 4'h0, 8'h00), 8'h00, 0);
    for (int a = 0; a < N; a++) chk("ram_content", mem[a], INV ? ~8'(a) : 8'(a));

    // stuck-at-0 bit 0 at address 5
    sa0[5] = 8'h01;
    run(mk(1'b0, 4'h5, 8'h04), 8'h00, 0);
    clear_faults();

    // stuck-at-0 bit 7 at addresses 3 and 9: first one reported
    sa0[3] = 8'h80;
    sa0[9] = 8'h80;
    run(mk(1'b0, 4'h3, 8'h03), 8'h80, 0);
    clear_faults();

    // pattern wrap, plus a start mid-run that must be ignored
    run(mk(1'b1, 4'h0, 8'h00), 8'hFE, 10);
    chk("wrap_addr1", mem[1], INV ? 8'h00 : 8'hFF);
    chk("wrap_addr2", mem[2], INV ? 8'hFF : 8'h00);

    // asynchronous abort in WRITE cycle 8
    do_start(8'h55, sc);
    for (int n = 0; n < 20 && (cyc - sc + 1) < 8; n++) @(negedge clk);
    chk("abort_cycle", cyc - sc + 1, 8);
    chk("abort_pre_wr_en", ram_wr_en, 1);
    chk("abort_pre_busy", busy, 1);
    #1;
    rst = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);

    // fresh run after abort
    run(mk(1'b1, 4'h0, 8'h00), 8'h00, 0);

    // stuck-at-1 bit 0 at address 5: only the inverted pass can see it
    sa1[5] = 8'h01;
    run(INV ? mk(1'b0, 4'h5, 8'hFB) : mk(1'b1, 4'h0, 8'h00), 8'h00, 0);
    clear_faults();

    // randomized seeds and faults against the reference model
    for (int t = 0; t < 12; t++) begin
      logic [7:0] s;
      int nf;
      clear_faults();
      nf = $urandom_range(0, 2);
      for (int k = 0; k < nf; k++) begin
        int a;
        a = $urandom_range(0, N - 1);
        if ($urandom_range(0, 1) == 1) sa0[a] = sa0[a] | (8'h01 << $urandom_range(0, 7));
        else                           sa1[a] = sa1[a] | (8'h01 << $urandom_range(0, 7));
      end
      s = 8'($urandom);
      run(model(s), s, 0);
    end
    clear_faults();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
